// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Sequencing control for the PC, IF/ID and ID/EX registers.
//            Each cycle it decides whether fetch/decode advance, stall, or are
//            squashed, and whether a bubble enters ID/EX. It handles:
//              - load-use stalls (one cycle)
//              - mult/div issue stalls (MD_CYCLES cycles in ID)
//              - taken-branch flushes (abort any pending mult/div)
// Ports    : clk, reset        - clock, synchronous active-high reset
//            id_rs, id_rt      - source fields of the instruction in ID
//            id_uses_rt        - ID instruction reads rt
//            id_md             - ID instruction is mult/div
//            ex_mem_read,ex_rt - load in EX and its destination
//            branch_taken      - branch/jump in EX resolved taken
//            pc_write, if_id_write, if_id_flush, id_ex_bubble - register controls
//            md_busy           - mult/div hold in progress
//            stall_count, flush_count - statistics counters
// Options  : define HAZARD_STATS_EN to build the saturating stall/flush
//            counters; otherwise both counter ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_md,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        md_busy,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // A single-cycle mult/div needs no hold at all, so it issues like any
    // other instruction. Otherwise the entry cycle is the first of
    // MD_CYCLES and the release cycle is the one where the counter hits 0.
    localparam bit              c_MD_STALL = (MD_CYCLES >= 2);
    localparam int              c_MD_INIT  = c_MD_STALL ? (MD_CYCLES - 2) : 0;
    localparam logic [CNT_W-1:0] c_MD_LOAD = c_MD_INIT[CNT_W-1:0];

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_md_cnt;
    logic [CNT_W-1:0]   w_md_cnt_nxt;
    logic               w_lu;

    // Register 0 is hard-wired, so a load targeting it can never be a hazard.
    assign w_lu = ex_mem_read && (ex_rt != 5'd0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        md_busy      = (r_state == MD_WAIT);
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            md_busy      = 1'b0;
            w_state_nxt  = RUN;
            w_md_cnt_nxt = '0;
        end else if (branch_taken) begin
            // Everything younger than the branch is on the wrong path,
            // including a mult/div still held in ID.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_state_nxt  = RUN;
            w_md_cnt_nxt = '0;
        end else if (r_state == MD_WAIT) begin
            if (r_md_cnt != '0) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                w_md_cnt_nxt = r_md_cnt - CNT_W'(1);
            end else begin
                w_state_nxt  = RUN;
            end
        end else if (w_lu) begin
            // The load moves on to MEM next cycle, so one stall suffices.
            // A mult/div in ID waits for the next cycle to begin its hold.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (id_md && c_MD_STALL) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            w_state_nxt  = MD_WAIT;
            w_md_cnt_nxt = c_MD_LOAD;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (branch_taken && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign stall_count = 16'h0000;
    assign flush_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Self-checking bench for pipeline_hazard_ctrl: a directed vector
//            table, randomized traffic against a behavioural model, and a
//            long branch run for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int MD = 4;

    typedef struct {
        bit         rst;
        logic [4:0] rs;
        logic [4:0] rt;
        bit         uses_rt;
        bit         md;
        bit         mem_read;
        logic [4:0] ex_rt;
        bit         br;
        logic [4:0] exp;   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy}
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_md, ex_mem_read, branch_taken;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy;
    logic [15:0] stall_count, flush_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model: cycles the current mult/div still has to spend in ID
    // after its first cycle, plus the saturating statistics.
    int m_left  = 0;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_hazard_ctrl #(.MD_CYCLES(MD), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_md(id_md),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .md_busy(md_busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, int rs, int rt, bit u, bit md, bit mr,
                                int ert, bit br, logic [4:0] exp);
        vec_t v;
        v.rst = r; v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = u; v.md = md;
        v.mem_read = mr; v.ex_rt = 5'(ert); v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit lu_of(vec_t v);
        return v.mem_read && (v.ex_rt != 0) &&
               ((v.ex_rt == v.rs) || (v.uses_rt && (v.ex_rt == v.rt)));
    endfunction

    function automatic logic [4:0] model_eval(vec_t v);
        if (v.rst)            return 5'b00110;
        if (v.br)             return {4'b1111, m_left > 0};
        if (m_left > 1)       return 5'b00011;
        if (m_left == 1)      return 5'b11001;
        if (lu_of(v))         return 5'b00010;
        if (v.md && MD > 1)   return 5'b00010;
        return 5'b11000;
    endfunction

    task automatic model_update(vec_t v, logic [4:0] e);
        if (v.rst) begin
            m_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (v.br)              m_left = 0;
            else if (m_left > 0)   m_left = m_left - 1;
            else if (!lu_of(v) && v.md && MD > 1) m_left = MD - 1;
            if (!e[4] && m_stall < 16'hFFFF) m_stall++;
            if (v.br && m_flush < 16'hFFFF)  m_flush++;
        end
    endtask

    // mode 0: drive only, 1: check against v.exp, 2: check against model
    task automatic step(vec_t v, int mode, string tag);
        logic [4:0] e, got;
        reset = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt;
        id_md = v.md; ex_mem_read = v.mem_read; ex_rt = v.ex_rt; branch_taken = v.br;
        @(negedge clk);
        e   = model_eval(v);
        got = {pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy};
        if (mode != 0) begin
            if (mode == 1) e = v.exp;
            chk({tag, ".pc_write"},     int'(got[4]), int'(e[4]));
            chk({tag, ".if_id_write"},  int'(got[3]), int'(e[3]));
            chk({tag, ".if_id_flush"},  int'(got[2]), int'(e[2]));
            chk({tag, ".id_ex_bubble"}, int'(got[1]), int'(e[1]));
            chk({tag, ".md_busy"},      int'(got[0]), int'(e[0]));
`ifdef HAZARD_STATS_EN
            chk({tag, ".stall_count"}, int'(stall_count), m_stall);
            chk({tag, ".flush_count"}, int'(flush_count), m_flush);
`else
            chk({tag, ".stall_count"}, int'(stall_count), 0);
            chk({tag, ".flush_count"}, int'(flush_count), 0);
`endif
        end
        @(posedge clk);
        model_update(v, model_eval(v));
        #1;
    endtask

    vec_t tbl[24];
    vec_t rv;

    initial begin
        //              rst rs rt u md mr ert br  exp{pc,ifw,fl,bub,busy}
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110); // reset
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000); // first run cycle
        tbl[3]  = mk(0, 5, 0, 0, 0, 1, 5, 0, 5'b00010); // load-use on rs
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000); // stall lasted 1 cycle
        tbl[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 5'b11000); // r0 destination
        tbl[6]  = mk(0, 3, 5, 0, 0, 1, 5, 0, 5'b11000); // rt not used
        tbl[7]  = mk(0, 3, 5, 1, 0, 1, 5, 0, 5'b00010); // rt used
        tbl[8]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00010); // md entry
        tbl[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00011);
        tbl[10] = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00011);
        tbl[11] = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b11001); // release
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
        tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00010); // md entry
        tbl[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00011);
        tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 1, 5'b11111); // branch aborts md
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000); // back in RUN
        tbl[17] = mk(0, 5, 0, 0, 0, 1, 5, 1, 5'b11110); // branch beats lu
        tbl[18] = mk(0, 5, 0, 0, 1, 1, 5, 0, 5'b00010); // lu beats md entry
        tbl[19] = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00010); // md entry next cycle
        tbl[20] = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00011);
        tbl[21] = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b00011);
        tbl[22] = mk(0, 0, 0, 0, 1, 0, 0, 0, 5'b11001);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);

        for (int i = 0; i < 24; i++)
            step(tbl[i], 1, $sformatf("vec%0d", i));

        // Randomized traffic with small register numbers to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            rv = mk(($urandom_range(0, 59) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), 5'b0);
            step(rv, 2, $sformatf("rnd%0d", i));
        end

        // Counter saturation: reset, then a long run of taken branches.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110), 1, "sat_reset");
        for (int i = 0; i < 70000; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b11110), 0, "sat");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b11000), 1, "sat_end");
`ifdef HAZARD_STATS_EN
        chk("flush_saturated", int'(flush_count), 16'hFFFF);
`else
        chk("flush_disabled", int'(flush_count), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
